// File: rtl/datapath_sequencer_if.sv
// Memory command/address bus between datapath_sequencer (master) and its memory (slave).
interface datapath_sequencer_if;
    logic [1:0]  mem_cmd;
    logic [8:0]  mem_addr;
    logic [15:0] mdata;
    logic        mem_ready;

    modport master (output mem_cmd, output mem_addr, input mdata, input mem_ready);
    modport slave  (input mem_cmd, input mem_addr, output mdata, output mem_ready);
endinterface

// File: rtl/datapath_sequencer.sv
// Multicycle fetch/decode/execute controller for the 16-bit register-file/ALU datapath.
// Conditional branches (opcode 001) are compiled in only when BRANCH_EN is defined.
module datapath_sequencer #(
    parameter logic [8:0] RESET_PC = 9'd0
) (
    input  logic                 clk,
    input  logic                 reset_n,
    datapath_sequencer_if.master mem,
    input  logic [2:0]           status,
    input  logic [15:0]          datapath_out,
    output logic [3:0]           vsel,
    output logic [2:0]           writenum,
    output logic [2:0]           readnum,
    output logic                 write,
    output logic                 loada,
    output logic                 loadb,
    output logic                 loadc,
    output logic [1:0]           shift,
    output logic                 asel,
    output logic                 bsel,
    output logic [1:0]           ALUop,
    output logic [15:0]          sximm5,
    output logic [15:0]          sximm8,
    output logic [8:0]           PC,
    output logic                 halted
);
    localparam logic [1:0] CmdNone  = 2'b00;
    localparam logic [1:0] CmdRead  = 2'b01;
    localparam logic [1:0] CmdWrite = 2'b10;

    typedef enum logic [4:0] {
        StRst, StIf1, StIf2, StUpdatePc, StDecode, StGetA, StGetB, StAlu, StWriteRd,
        StWriteImm, StAddr, StLatch, StMemRd, StWriteMem, StPass, StMemWr, StBranch, StHalt
    } state_e;

    state_e      r_state, w_state_d;
    logic [15:0] r_ir, w_ir_d;
    logic [8:0]  r_pc, w_pc_d;
    logic [8:0]  r_daddr, w_daddr_d;

    logic [2:0] w_opcode, w_rn, w_rd, w_rm;
    logic [1:0] w_op, w_sh;
    logic       w_is_str, w_is_mem, w_is_cmp, w_is_mov, w_take;
    logic       w_unused;

    logic [3:0] w_vsel;
    logic [2:0] w_writenum, w_readnum;
    logic       w_write, w_loada, w_loadb, w_loadc, w_asel, w_bsel, w_halted;
    logic [1:0] w_shift, w_aluop, w_mem_cmd;
    logic [8:0] w_mem_addr;

    assign w_opcode = r_ir[15:13];
    assign w_op     = r_ir[12:11];
    assign w_rn     = r_ir[10:8];
    assign w_rd     = r_ir[7:5];
    assign w_sh     = r_ir[4:3];
    assign w_rm     = r_ir[2:0];

    assign w_is_str = (w_opcode == 3'b100);
    assign w_is_mem = (w_opcode == 3'b011) || w_is_str;
    assign w_is_cmp = (w_opcode == 3'b101) && (w_op == 2'b01);
    assign w_is_mov = (w_opcode == 3'b110);

    assign sximm5   = {{11{r_ir[4]}}, r_ir[4:0]};
    assign sximm8   = {{8{r_ir[7]}}, r_ir[7:0]};
    assign PC       = r_pc;
    // Only the low 9 bits of register C form an address.
    assign w_unused = ^datapath_out[15:9];

    // Branch condition on Z=status[0], N=status[1], V=status[2].
    always_comb begin
        case (w_rn)
            3'd0:    w_take = 1'b1;
            3'd1:    w_take = status[0];
            3'd2:    w_take = !status[0];
            3'd3:    w_take = status[1] ^ status[2];
            3'd4:    w_take = (status[1] ^ status[2]) | status[0];
            default: w_take = 1'b0;
        endcase
    end

    always_comb begin
        w_state_d = r_state;
        w_pc_d    = r_pc;
        w_ir_d    = r_ir;
        w_daddr_d = r_daddr;
        case (r_state)
            StRst: begin
                w_pc_d    = RESET_PC;
                w_ir_d    = '0;
                w_daddr_d = '0;
                w_state_d = StIf1;
            end
            StIf1: w_state_d = StIf2;
            StIf2: begin
                if (mem.mem_ready) begin
                    w_ir_d    = mem.mdata;
                    w_state_d = StUpdatePc;
                end
            end
            StUpdatePc: begin
                w_pc_d    = r_pc + 9'd1;
                w_state_d = StDecode;
            end
            StDecode: begin
                w_state_d = StHalt;
                case (w_opcode)
                    3'b110: begin
                        if (w_op == 2'b10)      w_state_d = StWriteImm;
                        else if (w_op == 2'b00) w_state_d = StGetB;
                    end
                    3'b101: w_state_d = (w_op == 2'b11) ? StGetB : StGetA;
                    3'b011, 3'b100: if (w_op == 2'b00) w_state_d = StGetA;
`ifdef BRANCH_EN
                    3'b001: if (w_op == 2'b00 && w_rn <= 3'd4) w_state_d = StBranch;
`endif
                    default: ;
                endcase
            end
            StGetA:     w_state_d = w_is_mem ? StAddr : StGetB;
            StGetB:     w_state_d = w_is_str ? StPass : StAlu;
            StAlu:      w_state_d = w_is_cmp ? StIf1 : StWriteRd;
            StWriteRd:  w_state_d = StIf1;
            StWriteImm: w_state_d = StIf1;
            StAddr:     w_state_d = StLatch;
            StLatch: begin
                w_daddr_d = datapath_out[8:0];
                w_state_d = w_is_str ? StGetB : StMemRd;
            end
            StMemRd:    if (mem.mem_ready) w_state_d = StWriteMem;
            StWriteMem: w_state_d = StIf1;
            StPass:     w_state_d = StMemWr;
            StMemWr:    if (mem.mem_ready) w_state_d = StIf1;
            StBranch: begin
                // PC already points past the branch word.
                if (w_take) w_pc_d = r_pc + sximm8[8:0];
                w_state_d = StIf1;
            end
            StHalt:     w_state_d = StHalt;
            default:    w_state_d = StHalt;
        endcase
    end

    // Outputs are decoded from the next state so that they register alongside it.
    always_comb begin
        w_vsel     = 4'b0000;
        w_writenum = 3'd0;
        w_readnum  = 3'd0;
        w_write    = 1'b0;
        w_loada    = 1'b0;
        w_loadb    = 1'b0;
        w_loadc    = 1'b0;
        w_shift    = 2'b00;
        w_asel     = 1'b0;
        w_bsel     = 1'b0;
        w_aluop    = 2'b00;
        w_mem_cmd  = CmdNone;
        w_mem_addr = w_pc_d;
        w_halted   = 1'b0;
        case (w_state_d)
            StIf1, StIf2: w_mem_cmd = CmdRead;
            StGetA: begin
                w_readnum = w_rn;
                w_loada   = 1'b1;
            end
            StGetB: begin
                w_readnum = w_is_str ? w_rd : w_rm;
                w_loadb   = 1'b1;
            end
            StAlu: begin
                w_loadc = !w_is_cmp;
                w_shift = w_sh;
                w_asel  = w_is_mov;
                w_aluop = w_is_mov ? 2'b00 : w_op;
            end
            StWriteRd: begin
                w_vsel     = 4'b0001;
                w_writenum = w_rd;
                w_write    = 1'b1;
            end
            StWriteImm: begin
                w_vsel     = 4'b0100;
                w_writenum = w_rn;
                w_write    = 1'b1;
            end
            StAddr: begin
                w_bsel  = 1'b1;
                w_loadc = 1'b1;
            end
            StMemRd: begin
                w_mem_cmd  = CmdRead;
                w_mem_addr = w_daddr_d;
            end
            StWriteMem: begin
                w_mem_cmd  = CmdRead;
                w_mem_addr = w_daddr_d;
                w_vsel     = 4'b1000;
                w_writenum = w_rd;
                w_write    = 1'b1;
            end
            StPass: begin
                w_asel  = 1'b1;
                w_loadc = 1'b1;
            end
            StMemWr: begin
                w_mem_cmd  = CmdWrite;
                w_mem_addr = w_daddr_d;
            end
            StHalt:  w_halted = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_state      <= StRst;
            r_pc         <= RESET_PC;
            r_ir         <= '0;
            r_daddr      <= '0;
            vsel         <= 4'b0000;
            writenum     <= 3'd0;
            readnum      <= 3'd0;
            write        <= 1'b0;
            loada        <= 1'b0;
            loadb        <= 1'b0;
            loadc        <= 1'b0;
            shift        <= 2'b00;
            asel         <= 1'b0;
            bsel         <= 1'b0;
            ALUop        <= 2'b00;
            mem.mem_cmd  <= CmdNone;
            mem.mem_addr <= RESET_PC;
            halted       <= 1'b0;
        end else begin
            r_state      <= w_state_d;
            r_pc         <= w_pc_d;
            r_ir         <= w_ir_d;
            r_daddr      <= w_daddr_d;
            vsel         <= w_vsel;
            writenum     <= w_writenum;
            readnum      <= w_readnum;
            write        <= w_write;
            loada        <= w_loada;
            loadb        <= w_loadb;
            loadc        <= w_loadc;
            shift        <= w_shift;
            asel         <= w_asel;
            bsel         <= w_bsel;
            ALUop        <= w_aluop;
            mem.mem_cmd  <= w_mem_cmd;
            mem.mem_addr <= w_mem_addr;
            halted       <= w_halted;
        end
    end
endmodule

// File: tb/tb_datapath_sequencer.sv
// Directed bench for datapath_sequencer: fetch, MOV/ADD/LDR/STR sequences, HALT, PC wrap, branch.
module tb_datapath_sequencer;
    logic        clk = 1'b0;
    logic        reset_n;
    logic [2:0]  status;
    logic [15:0] datapath_out;
    logic [3:0]  vsel;
    logic [2:0]  writenum, readnum;
    logic        write, loada, loadb, loadc, asel, bsel, halted;
    logic [1:0]  shift, ALUop;
    logic [15:0] sximm5, sximm8;
    logic [8:0]  PC;

    logic [15:0] mem_q [512];
    int n_checks = 0;
    int n_fail   = 0;

    datapath_sequencer_if bus ();
    assign bus.mdata = mem_q[bus.mem_addr];

    datapath_sequencer #(.RESET_PC(9'd0)) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .mem          (bus),
        .status       (status),
        .datapath_out (datapath_out),
        .vsel         (vsel),
        .writenum     (writenum),
        .readnum      (readnum),
        .write        (write),
        .loada        (loada),
        .loadb        (loadb),
        .loadc        (loadc),
        .shift        (shift),
        .asel         (asel),
        .bsel         (bsel),
        .ALUop        (ALUop),
        .sximm5       (sximm5),
        .sximm8       (sximm8),
        .PC           (PC),
        .halted       (halted)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wait_fetch(input logic [8:0] addr, input int budget, output bit found);
        found = 1'b0;
        for (int i = 0; i < budget && !found; i++) begin
            @(negedge clk);
            if (bus.mem_cmd == 2'b01 && bus.mem_addr == addr) found = 1'b1;
        end
    endtask

    initial begin
        bit found;
        reset_n       = 1'b0;
        status        = 3'b000;
        datapath_out  = 16'h0000;
        bus.mem_ready = 1'b1;
        for (int i = 0; i < 512; i++) mem_q[i] = 16'hE000;
        mem_q[0] = 16'hD305;  // MOV R3,#5
        mem_q[1] = 16'hA248;  // ADD Rn=2,Rd=2,Rm=0,LSL#1
        mem_q[2] = 16'h6382;  // LDR R4,[R3,#2]
        mem_q[3] = 16'h8380;  // STR R4,[R3,#0]
        mem_q[4] = 16'hE000;  // HALT

        tick(1);
        check("rst_pc", PC, 9'd0);
        check("rst_cmd", bus.mem_cmd, 2'b00);
        check("rst_halted", halted, 1'b0);
        check("rst_write", write, 1'b0);
        tick(1);
        reset_n = 1'b1;

        // MOV R3,#5
        tick(1);
        check("if1_cmd", bus.mem_cmd, 2'b01);
        check("if1_addr", bus.mem_addr, 9'd0);
        tick(1);
        check("if2_cmd", bus.mem_cmd, 2'b01);
        tick(3);
        check("movi_vsel", vsel, 4'b0100);
        check("movi_writenum", writenum, 3'd3);
        check("movi_write", write, 1'b1);
        check("movi_sximm8", sximm8, 16'h0005);
        check("movi_pc", PC, 9'd1);
        tick(1);
        check("movi_next_addr", bus.mem_addr, 9'd1);
        check("movi_next_cmd", bus.mem_cmd, 2'b01);

        // ADD
        tick(4);
        check("add_geta_readnum", readnum, 3'd2);
        check("add_geta_loada", loada, 1'b1);
        tick(1);
        check("add_getb_readnum", readnum, 3'd0);
        check("add_getb_loadb", loadb, 1'b1);
        tick(1);
        check("add_alu_shift", shift, 2'b01);
        check("add_alu_op", ALUop, 2'b00);
        check("add_alu_loadc", loadc, 1'b1);
        check("add_alu_asel", asel, 1'b0);
        tick(1);
        check("add_wr_writenum", writenum, 3'd2);
        check("add_wr_vsel", vsel, 4'b0001);
        check("add_wr_write", write, 1'b1);

        // LDR with a 3-cycle memory stall
        tick(1);
        check("ldr_if1_addr", bus.mem_addr, 9'd2);
        tick(4);
        check("ldr_geta_readnum", readnum, 3'd3);
        check("ldr_sximm5", sximm5, 16'h0002);
        tick(1);
        check("ldr_addr_bsel", bsel, 1'b1);
        check("ldr_addr_loadc", loadc, 1'b1);
        datapath_out = 16'h0007;
        tick(1);
        check("ldr_latch_cmd", bus.mem_cmd, 2'b00);
        bus.mem_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick(1);
            check("ldr_wait_cmd", bus.mem_cmd, 2'b01);
            check("ldr_wait_addr", bus.mem_addr, 9'd7);
            check("ldr_wait_write", write, 1'b0);
            if (i == 3) bus.mem_ready = 1'b1;
        end
        tick(1);
        check("ldr_wb_cmd", bus.mem_cmd, 2'b01);
        check("ldr_wb_vsel", vsel, 4'b1000);
        check("ldr_wb_writenum", writenum, 3'd4);
        check("ldr_wb_write", write, 1'b1);
        tick(1);
        check("ldr_next_addr", bus.mem_addr, 9'd3);

        // STR
        tick(4);
        check("str_geta_readnum", readnum, 3'd3);
        tick(1);
        datapath_out = 16'h0209;
        tick(1);
        tick(1);
        check("str_getb_readnum", readnum, 3'd4);
        check("str_getb_loadb", loadb, 1'b1);
        tick(1);
        check("str_pass_asel", asel, 1'b1);
        check("str_pass_loadc", loadc, 1'b1);
        tick(1);
        check("str_wr_cmd", bus.mem_cmd, 2'b10);
        check("str_wr_addr", bus.mem_addr, 9'd9);
        tick(1);
        check("str_next_addr", bus.mem_addr, 9'd4);

        // HALT is absorbing
        tick(4);
        for (int i = 0; i < 20; i++) begin
            bus.mem_ready = i[0];
            tick(1);
            check("halt_halted", halted, 1'b1);
            check("halt_cmd", bus.mem_cmd, 2'b00);
        end
        bus.mem_ready = 1'b1;
        reset_n = 1'b0;
        tick(1);
        check("halt_rst_halted", halted, 1'b0);
        check("halt_rst_pc", PC, 9'd0);

        // Reset during a stalled fetch
        bus.mem_ready = 1'b0;
        reset_n = 1'b1;
        tick(3);
        check("stall_if2_cmd", bus.mem_cmd, 2'b01);
        reset_n = 1'b0;
        tick(1);
        check("stall_rst_cmd", bus.mem_cmd, 2'b00);
        bus.mem_ready = 1'b1;

        // PC wrap 511 -> 0
        for (int i = 0; i < 512; i++) mem_q[i] = 16'hD001;
        reset_n = 1'b1;
        wait_fetch(9'd511, 3000, found);
        check("wrap_reach511", found, 1'b1);
        check("wrap_pc511", PC, 9'd511);
        tick(5);
        check("wrap_addr0", bus.mem_addr, 9'd0);
        check("wrap_pc0", PC, 9'd0);
        check("wrap_cmd", bus.mem_cmd, 2'b01);

        // Branch (BEQ -2 at address 4)
        reset_n = 1'b0;
        tick(2);
        mem_q[4] = 16'h21FE;
        status = 3'b001;
        reset_n = 1'b1;
        wait_fetch(9'd4, 100, found);
        check("br_reach4", found, 1'b1);
        tick(5);
`ifdef BRANCH_EN
        check("br_taken_addr", bus.mem_addr, 9'd3);
        check("br_taken_pc", PC, 9'd3);
        status = 3'b000;
        tick(5);
        check("br_refetch_addr", bus.mem_addr, 9'd4);
        tick(5);
        check("br_fall_addr", bus.mem_addr, 9'd5);
        check("br_fall_pc", PC, 9'd5);
`else
        check("br_off_halted", halted, 1'b1);
        check("br_off_cmd", bus.mem_cmd, 2'b00);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
